mips_mc_main_control: RTL and testbench
=======================================

# mips_mc_main_control

Main control FSM for the multi-cycle MIPS core. It is the driving end of the ALU control interface: each cycle it issues `alu_op[1:0]` and `alu_funct[2:0]` to the ALU control unit, plus every datapath enable and mux select. It sequences fetch, decode, execute, memory and writeback, and stalls on a req/ack memory handshake. It also counts retired instructions and traps illegal opcodes.

## Interface
- `RETIRE_W`, 32, width of retired-instruction counter
- `clk` input 1 system clock, rising edge
- `rst_n` input 1 asynchronous active-low reset
- `opcode` input 6 IR[31:26], stable from DECODE through end of instruction
- `funct` input 6 IR[5:0]
- `zero` input 1 ALU zero flag (consumed by datapath via `pc_write_cond`)
- `mem_ack` input 1 memory completes the current request this cycle
- `mem_req` output 1 memory request; held until `mem_ack`
- `mem_we` output 1 write qualifier for `mem_req`
- `i_or_d` output 1 address select: 0 = PC, 1 = ALUOut
- `ir_write` output 1 load IR
- `pc_write` output 1 unconditional PC load
- `pc_write_cond` output 1 PC load when `zero`
- `pc_src` output 2 00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_src_a` output 1 0 = PC, 1 = reg A
- `alu_src_b` output 2 00 = reg B, 01 = const 4, 10 = imm, 11 = imm<<2
- `ext_zero` output 1 imm is zero-extended (1) or sign-extended (0)
- `alu_op` output 2 to ALU control: 00 = use `alu_funct`, 01 = SUB (code 001), 10 = OR (code 100), 11 = ADD (code 000)
- `alu_funct` output 3 ALU code when `alu_op`=00, else 000
- `reg_write` output 1 register file write
- `reg_dst` output 1 write dest: 0 = rt, 1 = rd
- `mem_to_reg` output 1 write data: 0 = ALUOut, 1 = MDR
- `illegal_op` output 1 sticky trap flag
- `retired` output RETIRE_W count of completed instructions

## Operation
- Supported opcodes: R 000000, lw 100011, sw 101011, beq 000100, addi 001000, ori 001101, j 000010. All others are illegal.
- States and outputs. Any output not listed is 0, and `alu_op` is 11.
  - IDLE: reset state; all outputs 0 → FETCH.
  - FETCH: `mem_req`=1, `i_or_d`=0. When `mem_ack`=1: `ir_write`=1, `pc_write`=1, `alu_src_b`=01, `pc_src`=00 → DECODE. Otherwise stay.
  - DECODE: `alu_src_b`=11, `alu_op`=11 (branch target into ALUOut). Next state by opcode: lw/sw → MEMADR, R → EXEC, beq → BRANCH, addi/ori → IEXEC, j → JUMP, other → TRAP.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10 → MEMRD (lw) or MEMWR (sw).
  - MEMRD: `mem_req`=1, `i_or_d`=1; on `mem_ack` → MEMWB.
  - MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0 → FETCH.
  - MEMWR: `mem_req`=1, `mem_we`=1, `i_or_d`=1; on `mem_ack` → FETCH.
  - EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=00, `alu_funct`=`funct[2:0]` → ALUWB.
  - ALUWB: `reg_write`=1, `reg_dst`=1 → FETCH.
  - BRANCH: `alu_src_a`=1, `alu_op`=01, `pc_write_cond`=1, `pc_src`=01 → FETCH.
  - IEXEC: `alu_src_a`=1, `alu_src_b`=10. addi: `alu_op`=11, `ext_zero`=0. ori: `alu_op`=10, `ext_zero`=1. → IWB.
  - IWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
  - JUMP: `pc_write`=1, `pc_src`=10 → FETCH.
  - TRAP: `illegal_op`=1, all enables 0; held until reset.
- `retired` increments by 1 on each transition into FETCH from MEMWB, MEMWR (acked), ALUWB, BRANCH, IWB or JUMP. It wraps modulo 2^RETIRE_W.

## Timing
- Reset (async assert, sync release): state = IDLE, `retired` = 0, `illegal_op` = 0, all outputs 0. Assertion mid-instruction aborts immediately; `mem_req` drops combinationally.
- First FETCH request is issued on the 2nd rising edge after `rst_n` deasserts (IDLE lasts 1 cycle).
- Outputs are combinational from state. `ir_write`/`pc_write` in FETCH are additionally qualified by `mem_ack` (Mealy).
- Handshake:
  - `mem_req` rises on state entry and stays high with `i_or_d`/`mem_we` stable until the cycle `mem_ack`=1.
  - Zero-wait ack (in the same cycle as `mem_req` rising) is legal.
  - `mem_ack` while `mem_req`=0 is ignored.
- Cycles per instruction at zero wait: lw 5, sw 4, R 4, addi/ori 4, beq 3, j 3. Each memory wait cycle adds 1.

## Test plan
- Reset then R-type with funct=100101, zero-wait memory → ALUWB follows EXEC (`alu_op`=00, `alu_funct`=101), `reg_dst`=1, `retired`=1 after 1+4 cycles.
- lw with `mem_ack` delayed 3 cycles in FETCH and 2 in MEMRD → `mem_req` stays high with no `ir_write` until ack; MEMWB has `mem_to_reg`=1; total 10 cycles.
- beq then j → BRANCH: `alu_op`=01, `pc_write_cond`=1, `pc_src`=01. JUMP: `pc_write`=1, `pc_src`=10. `retired` goes 0→1→2.
- ori vs addi → IEXEC: `alu_op`=10/`ext_zero`=1 for ori, `alu_op`=11/`ext_zero`=0 for addi; IWB has `reg_dst`=0.
- opcode 111111 → TRAP after DECODE; `illegal_op`=1 held for 20 cycles, `retired` unchanged, `mem_req`=0.
- `rst_n` low during MEMWR wait → all outputs 0 immediately, `retired`=0. After release: IDLE for 1 cycle, then FETCH.

Source files
------------

// File: rtl/mips_mc_main_control.sv
// Main control FSM for the multi-cycle MIPS core.
// Sequences fetch/decode/execute/memory/writeback, drives every datapath
// enable and mux select, and is the driving end of the ALU control
// interface (alu_op/alu_funct). Stalls on a req/ack memory handshake,
// counts retired instructions and traps illegal opcodes.
//
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   opcode, funct     IR[31:26], IR[5:0]
//   zero              ALU zero flag (used by datapath with pc_write_cond)
//   mem_ack           memory completes current request this cycle
//   mem_req, mem_we   memory request and write qualifier
//   i_or_d            address select: 0 = PC, 1 = ALUOut
//   ir_write          load IR
//   pc_write          unconditional PC load
//   pc_write_cond     PC load when zero
//   pc_src            00 ALU result, 01 ALUOut, 10 jump target
//   alu_src_a         0 PC, 1 reg A
//   alu_src_b         00 reg B, 01 const 4, 10 imm, 11 imm<<2
//   ext_zero          zero-extend (1) / sign-extend (0) immediate
//   alu_op            00 use alu_funct, 01 SUB, 10 OR, 11 ADD
//   alu_funct         ALU code when alu_op = 00, else 000
//   reg_write         register file write
//   reg_dst           0 rt, 1 rd
//   mem_to_reg        0 ALUOut, 1 MDR
//   illegal_op        trap flag, held until reset
//   retired           completed-instruction count (wraps)
module mips_mc_main_control #(
  parameter int unsigned RETIRE_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic                zero,
  input  logic                mem_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic                i_or_d,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic [1:0]          pc_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                ext_zero,
  output logic [1:0]          alu_op,
  output logic [2:0]          alu_funct,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                illegal_op,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_IEXEC,
    S_IWB,
    S_JUMP,
    S_TRAP
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   retire_evt;

  // zero is consumed by the datapath; funct[5:3] has no ALU code meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, zero, funct[5:3]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired <= '0;
    end else if (retire_evt) begin
      retired <= retired + RETIRE_W'(1);
    end
  end

  always_comb begin
    state_nxt     = state;
    retire_evt    = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    alu_op        = 2'b11;
    alu_funct     = 3'b000;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    illegal_op    = 1'b0;

    unique case (state)
      S_IDLE: begin
        alu_op    = 2'b00;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        // IR/PC loads are Mealy: they fire only in the acked cycle.
        if (mem_ack) begin
          ir_write  = 1'b1;
          pc_write  = 1'b1;
          alu_src_b = 2'b01;
          pc_src    = 2'b00;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW:    state_nxt = S_MEMADR;
          OP_R:            state_nxt = S_EXEC;
          OP_BEQ:          state_nxt = S_BRANCH;
          OP_ADDI, OP_ORI: state_nxt = S_IEXEC;
          OP_J:            state_nxt = S_JUMP;
          default:         state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ack) begin
          state_nxt = S_MEMWB;
        end
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_nxt  = S_FETCH;
        retire_evt = 1'b1;
      end
      S_MEMWR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ack) begin
          state_nxt  = S_FETCH;
          retire_evt = 1'b1;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b00;
        alu_funct = funct[2:0];
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        state_nxt  = S_FETCH;
        retire_evt = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        state_nxt     = S_FETCH;
        retire_evt    = 1'b1;
      end
      S_IEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (opcode == OP_ORI) begin
          alu_op   = 2'b10;
          ext_zero = 1'b1;
        end
        state_nxt = S_IWB;
      end
      S_IWB: begin
        reg_write  = 1'b1;
        state_nxt  = S_FETCH;
        retire_evt = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        state_nxt  = S_FETCH;
        retire_evt = 1'b1;
      end
      S_TRAP: begin
        illegal_op = 1'b1;
      end
      default: begin
        alu_op    = 2'b00;
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mips_mc_main_control.sv
// Directed self-checking bench for mips_mc_main_control.
module tb_mips_mc_main_control;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ack;
  logic        mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
  logic [1:0]  pc_src;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        ext_zero;
  logic [1:0]  alu_op;
  logic [2:0]  alu_funct;
  logic        reg_write, reg_dst, mem_to_reg, illegal_op;
  logic [31:0] retired;

  int n_checks = 0;
  int n_errors = 0;

  mips_mc_main_control #(.RETIRE_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ack(mem_ack), .mem_req(mem_req), .mem_we(mem_we), .i_or_d(i_or_d),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_zero(ext_zero), .alu_op(alu_op), .alu_funct(alu_funct),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_zero;
    logic [1:0] alu_op;
    logic [2:0] alu_funct;
    logic       reg_write, reg_dst, mem_to_reg, illegal_op;
  } ctl_t;

  typedef enum int {
    T_IDLE, T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR,
    T_EXEC, T_ALUWB, T_BRANCH, T_IEXEC, T_IWB, T_JUMP, T_TRAP
  } tst_e;

  ctl_t obs;
  assign obs = {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
                pc_src, alu_src_a, alu_src_b, ext_zero, alu_op, alu_funct,
                reg_write, reg_dst, mem_to_reg, illegal_op};

  // Hand-written output table per state.
  function automatic ctl_t exp_ctl(input tst_e s, input logic ack,
                                   input logic [5:0] op, input logic [5:0] fn);
    ctl_t e;
    e = '0;
    e.alu_op = 2'b11;
    case (s)
      T_IDLE:   e.alu_op = 2'b00;
      T_FETCH: begin
        e.mem_req = 1'b1;
        if (ack) begin
          e.ir_write = 1'b1; e.pc_write = 1'b1; e.alu_src_b = 2'b01;
        end
      end
      T_DECODE: e.alu_src_b = 2'b11;
      T_MEMADR: begin e.alu_src_a = 1'b1; e.alu_src_b = 2'b10; end
      T_MEMRD:  begin e.mem_req = 1'b1; e.i_or_d = 1'b1; end
      T_MEMWB:  begin e.reg_write = 1'b1; e.mem_to_reg = 1'b1; end
      T_MEMWR:  begin e.mem_req = 1'b1; e.mem_we = 1'b1; e.i_or_d = 1'b1; end
      T_EXEC: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b00; e.alu_funct = fn[2:0];
      end
      T_ALUWB:  begin e.reg_write = 1'b1; e.reg_dst = 1'b1; end
      T_BRANCH: begin
        e.alu_src_a = 1'b1; e.alu_op = 2'b01; e.pc_write_cond = 1'b1;
        e.pc_src = 2'b01;
      end
      T_IEXEC: begin
        e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        if (op == 6'b001101) begin e.alu_op = 2'b10; e.ext_zero = 1'b1; end
      end
      T_IWB:    e.reg_write = 1'b1;
      T_JUMP:   begin e.pc_write = 1'b1; e.pc_src = 2'b10; end
      T_TRAP:   e.illegal_op = 1'b1;
      default:  e = '0;
    endcase
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input tst_e s);
    check(tag, 32'(obs), 32'(exp_ctl(s, mem_ack, opcode, funct)));
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Runs a zero-wait 3/4-state instruction from FETCH back to FETCH.
  task automatic run_short(input string tag, input logic [5:0] op,
                           input tst_e s1, input tst_e s2, input int n_mid);
    opcode = op; mem_ack = 1'b1; #1 expect_st({tag, "_fetch"}, T_FETCH);
    tick(); mem_ack = 1'b0; #1 expect_st({tag, "_decode"}, T_DECODE);
    tick(); #1 expect_st({tag, "_s1"}, s1);
    if (n_mid > 1) begin
      tick(); #1 expect_st({tag, "_s2"}, s2);
    end
    tick();
  endtask

  int n;

  initial begin
    rst_n = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0;
    repeat (3) tick();
    expect_st("rst_ctl", T_IDLE);
    check("rst_retired", retired, 32'd0);
    rst_n = 1'b1;
    #1 expect_st("rel_idle", T_IDLE);
    tick();

    // R-type, funct 100101, zero-wait
    opcode = 6'b000000; funct = 6'b100101; mem_ack = 1'b1;
    #1 expect_st("r_fetch", T_FETCH);
    tick(); mem_ack = 1'b0; #1 expect_st("r_decode", T_DECODE);
    tick(); #1 expect_st("r_exec", T_EXEC);
    check("r_alu_funct", 32'(alu_funct), 32'h5);
    check("r_ret_pre", retired, 32'd0);
    tick(); #1 expect_st("r_aluwb", T_ALUWB);
    tick(); #1 check("r_retired", retired, 32'd1);
    expect_st("r_back_fetch", T_FETCH);

    // lw: 3 wait cycles in FETCH, 2 in MEMRD
    opcode = 6'b100011; funct = '0; n = 0;
    for (int i = 0; i < 3; i++) begin
      #1 expect_st("lw_fetch_wait", T_FETCH);
      check("lw_no_irw", 32'(ir_write), 32'd0);
      tick(); n++;
    end
    mem_ack = 1'b1; #1 expect_st("lw_fetch_ack", T_FETCH);
    tick(); n++; mem_ack = 1'b0; #1 expect_st("lw_decode", T_DECODE);
    tick(); n++; #1 expect_st("lw_memadr", T_MEMADR);
    tick(); n++;
    for (int i = 0; i < 2; i++) begin
      #1 expect_st("lw_memrd_wait", T_MEMRD);
      tick(); n++;
    end
    mem_ack = 1'b1; #1 expect_st("lw_memrd_ack", T_MEMRD);
    tick(); n++; mem_ack = 1'b0; #1 expect_st("lw_memwb", T_MEMWB);
    tick(); n++;
    #1 check("lw_cycles", n, 32'd10);
    check("lw_retired", retired, 32'd2);

    run_short("beq", 6'b000100, T_BRANCH, T_BRANCH, 1);
    #1 check("beq_retired", retired, 32'd3);
    run_short("j", 6'b000010, T_JUMP, T_JUMP, 1);
    #1 check("j_retired", retired, 32'd4);
    run_short("ori", 6'b001101, T_IEXEC, T_IWB, 2);
    #1 check("ori_retired", retired, 32'd5);
    run_short("addi", 6'b001000, T_IEXEC, T_IWB, 2);
    #1 check("addi_retired", retired, 32'd6);

    // sw with one wait cycle in MEMWR
    opcode = 6'b101011; mem_ack = 1'b1; #1 expect_st("sw_fetch", T_FETCH);
    tick(); mem_ack = 1'b0; #1 expect_st("sw_decode", T_DECODE);
    tick(); #1 expect_st("sw_memadr", T_MEMADR);
    tick(); #1 expect_st("sw_memwr_wait", T_MEMWR);
    tick(); mem_ack = 1'b1; #1 expect_st("sw_memwr_ack", T_MEMWR);
    check("sw_ret_pre", retired, 32'd6);
    tick(); mem_ack = 1'b0; #1 check("sw_retired", retired, 32'd7);

    // illegal opcode: trap held, stray acks ignored
    opcode = 6'b111111; mem_ack = 1'b1; #1 expect_st("ill_fetch", T_FETCH);
    tick(); mem_ack = 1'b0; #1 expect_st("ill_decode", T_DECODE);
    tick();
    for (int i = 0; i < 20; i++) begin
      mem_ack = i[0];
      #1 expect_st("trap_hold", T_TRAP);
      check("trap_retired", retired, 32'd7);
      tick();
    end
    mem_ack = 1'b0;
    rst_n = 1'b0;
    #1 expect_st("trap_rst_ctl", T_IDLE);
    check("trap_rst_ret", retired, 32'd0);
    tick(); rst_n = 1'b1; tick();

    run_short("j2", 6'b000010, T_JUMP, T_JUMP, 1);
    #1 check("j2_retired", retired, 32'd1);

    // reset during MEMWR wait
    opcode = 6'b101011; mem_ack = 1'b1; #1 expect_st("sw2_fetch", T_FETCH);
    tick(); mem_ack = 1'b0; #1 expect_st("sw2_decode", T_DECODE);
    tick(); #1 expect_st("sw2_memadr", T_MEMADR);
    tick(); #1 expect_st("sw2_memwr_wait", T_MEMWR);
    rst_n = 1'b0;
    #1 expect_st("abort_ctl", T_IDLE);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_retired", retired, 32'd0);
    tick(); rst_n = 1'b1;
    #1 expect_st("abort_rel_idle", T_IDLE);
    tick(); #1 expect_st("abort_fetch", T_FETCH);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
